// File: rtl/gate_chk_pkg.sv
// Shared types and reference truth tables for the gate truth checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } chk_state_t;

    // Bit i is the required gate output for input vector i.
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_chk_settle_timer.sv
// Loadable down-counter that sets how long each vector is held before sampling.
module gate_chk_settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= W'(SETTLE_CYCLES - 1);
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector onto a gate under test and checks its output against a truth table.
//   state  | meaning
//   IDLE   | waiting for start after reset
//   SETTLE | current vector driven, waiting for the gate to settle
//   SAMPLE | compare dut_out with the truth table, advance or finish
//   DONE   | results held until the next start
module gate_truth_checker
    import gate_chk_pkg::*;
#(
    parameter int                            N_INPUTS      = 2,
    parameter int                            SETTLE_CYCLES = 1,
    parameter logic [(1 << N_INPUTS) - 1:0] EXPECTED      = TT_NOR2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                dut_out,
    output logic [N_INPUTS-1:0] stim,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic [N_INPUTS-1:0] first_fail_vec,
    output logic                first_fail_valid
);
    chk_state_t          state, state_n;
    logic [N_INPUTS-1:0] stim_n;
    logic [N_INPUTS:0]   err_n;
    logic [N_INPUTS-1:0] ffv_n;
    logic                ffvld_n;
    logic                pass_n;
    logic                tmr_load, tmr_dec, tmr_zero;
    logic                mismatch;

    gate_chk_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .dec  (tmr_dec),
        .zero (tmr_zero)
    );

    // Case inequality so an X or Z from the gate is reported as a failure.
    assign mismatch = (dut_out !== EXPECTED[stim]);

    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            stim             <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else begin
            state            <= state_n;
            stim             <= stim_n;
            err_count        <= err_n;
            first_fail_vec   <= ffv_n;
            first_fail_valid <= ffvld_n;
            pass             <= pass_n;
        end
    end

    always_comb begin
        state_n  = state;
        stim_n   = stim;
        err_n    = err_count;
        ffv_n    = first_fail_vec;
        ffvld_n  = first_fail_valid;
        pass_n   = pass;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stim_n   = '0;
                    err_n    = '0;
                    ffv_n    = '0;
                    ffvld_n  = 1'b0;
                    pass_n   = 1'b0;
                    tmr_load = 1'b1;
                    state_n  = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_zero)
                    state_n = SAMPLE;
                else
                    tmr_dec = 1'b1;
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_n = err_count + 1'b1;
                    if (!first_fail_valid) begin
                        ffv_n   = stim;
                        ffvld_n = 1'b1;
                    end
                end
                // The verdict must include a mismatch on the last vector.
                if (&stim) begin
                    pass_n  = (err_n == '0);
                    state_n = DONE;
                end else begin
                    stim_n   = stim + 1'b1;
                    tmr_load = 1'b1;
                    state_n  = SETTLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Hardware self-checking response end for single-output combinational gate blocks (NOR, NAND, etc.).
- Drives every input combination onto a gate under test, waits a settle time, and samples the gate output.
- Compares each sample against a parameterised truth table and reports error count, first failing vector and pass/fail.
- Stimulus plus check happen synchronously in one block, so it can sit beside any gate module in simulation or on a board.

Parameters:
- N_INPUTS, 2, number of gate inputs; the checker sweeps 2^N_INPUTS vectors.
- SETTLE_CYCLES, 1, number of cycles (>=1) each vector is held before sampling.
- EXPECTED, 4'b0001, truth table of width 2^N_INPUTS; bit i is the required output for input vector i. The default is NOR2: only vector 00 gives 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; sampled in IDLE or DONE only.
- dut_out  input  1  output of the gate under test.
- stim  output  N_INPUTS  input vector driven to the gate under test; bit 0 maps to input1, bit 1 to input2.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high in DONE until the next start.
- pass  output  1  valid while done=1; high iff err_count==0.
- err_count  output  N_INPUTS+1  number of mismatching vectors in the last sweep.
- first_fail_vec  output  N_INPUTS  stim value of the first mismatch.
- first_fail_valid  output  1  high once any mismatch has been recorded in the current sweep.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0.
  - Settle counter=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1, at that edge:
  - stim<=0, err_count<=0, first_fail_valid<=0, first_fail_vec<=0, done<=0, pass<=0.
  - Settle counter<=SETTLE_CYCLES-1, busy<=1, go to SETTLE.
- SETTLE:
  - Hold stim.
  - If counter==0, go to SAMPLE; otherwise decrement.
- SAMPLE (one cycle):
  - Mismatch when dut_out !== EXPECTED[stim]. X or Z on dut_out counts as a mismatch.
  - On mismatch: err_count+=1; if first_fail_valid==0, set first_fail_vec<=stim and first_fail_valid<=1.
  - If stim is all ones: go to DONE, busy<=0, done<=1, pass<=(final err_count==0). The final count includes this cycle's mismatch.
  - Otherwise: stim<=stim+1, reload the settle counter, go to SETTLE.
- DONE:
  - All result outputs hold.
  - stim holds the last vector (all ones).
- Timing: start sampled at edge k gives done=1 after edge k+2^N_INPUTS*(SETTLE_CYCLES+1). Default case: k+8.
- Counter width: stim increments only inside the sweep and never wraps during a sweep. err_count cannot overflow because its maximum is 2^N_INPUTS.
- start while busy=1 is ignored with no effect.
- start held high: a new sweep begins on every cycle in which the FSM is in DONE, giving back-to-back sweeps.
- Reset mid-sweep returns all outputs to reset values immediately; no partial result is retained.
- dut_out is sampled only in SAMPLE; its value in other states is don't-care.

Decomposition:
- Package gate_chk_pkg holds:
  - state enum typedef chk_state_t {IDLE, SETTLE, SAMPLE, DONE}.
  - Truth table constants TT_NOR2=4'b0001, TT_NAND2=4'b0111, TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110.
- One sub-module is natural: gate_chk_settle_timer, a loadable down-counter with a zero flag, parameterised by SETTLE_CYCLES.
- Sweep FSM, compare logic and result registers stay in the top level.

Test Plan:
1. Correct NOR2 model, defaults, start pulse at edge k -> done=1 at edge k+8; pass=1, err_count=0, first_fail_valid=0; stim visits 00,01,10,11 in order, each held 2 cycles.
2. Gate under test stuck-at-0 with EXPECTED=TT_NOR2 -> err_count=1, first_fail_vec=2'b00, first_fail_valid=1, pass=0.
3. OR2 model against TT_NOR2 -> err_count=4, first_fail_vec=00, pass=0; a following sweep with TT_OR2 and start -> err_count=0, pass=1, and previous results cleared on start.
4. Pulse start again at edges k+3 and k+5 during a sweep -> no restart; done still at edge k+8 with the same results as scenario 1.
5. Assert rst at edge k+5 mid-sweep -> stim, busy, err_count and all other outputs at 0 immediately; after release, a start runs a full correct sweep.
6. N_INPUTS=3, SETTLE_CYCLES=3, EXPECTED=8'h7F, correct NAND3 model -> done at edge k+32, pass=1; dut_out forced to X at vector 5 -> err_count=1, first_fail_vec=3'd5.
